// File: rtl/pingpong_bank_ctrl.sv
// pingpong_bank_ctrl: N-bank ping-pong buffer between two layer engines.
// Producer fills banks round-robin; consumer drains closed banks in order.
module pingpong_bank_ctrl #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 12,
    parameter int NUM_BANKS = 2,
    parameter int RD_LAT    = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              wr_valid,
    output logic                              wr_ready,
    input  logic [DATA_W-1:0]                 wr_data,
    input  logic                              wr_last,
    output logic                              rd_avail,
    output logic [ADDR_W:0]                   rd_len,
    input  logic                              rd_en,
    input  logic [ADDR_W-1:0]                 rd_addr,
    output logic [DATA_W-1:0]                 rd_data,
    output logic                              rd_data_valid,
    input  logic                              rd_done,
    output logic [$clog2(NUM_BANKS+1)-1:0]    banks_full,
    output logic                              overflow,
    output logic [NUM_BANKS-1:0]              bram_wea,
    output logic [ADDR_W-1:0]                 bram_addra,
    output logic [DATA_W-1:0]                 bram_dina,
    output logic [ADDR_W-1:0]                 bram_addrb,
    input  logic [NUM_BANKS*DATA_W-1:0]       bram_doutb
);
    localparam int IW = $clog2(NUM_BANKS);
    localparam int BW = $clog2(NUM_BANKS + 1);
    localparam logic [IW-1:0] LAST_B = IW'(NUM_BANKS - 1);

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL,
        DRAINING
    } bank_st_t;

    bank_st_t          st   [NUM_BANKS];
    logic [ADDR_W:0]   len  [NUM_BANKS];
    logic [IW-1:0]     wb;
    logic [IW-1:0]     rb;
    logic [ADDR_W-1:0] wcnt;
    logic [RD_LAT-1:0] vpipe;
    logic [IW-1:0]     ipipe [RD_LAT];
    logic              wr_fire;
    logic              wr_close;
    logic              rd_fire;
    logic              rel;

    function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
        return (i == LAST_B) ? '0 : i + 1'b1;
    endfunction

    assign wr_ready = (st[wb] == EMPTY) || (st[wb] == FILLING);
    assign wr_fire  = wr_valid & wr_ready;
    assign wr_close = wr_fire & (wr_last | (&wcnt));

    // A just-closed bank is held back until its final registered write lands
    assign rd_avail = (st[rb] == DRAINING) ||
                      ((st[rb] == FULL) && !bram_wea[rb]);
    assign rd_fire  = rd_en & rd_avail;
    assign rel      = rd_done & rd_avail;
    assign rd_len   = len[rb];

    assign bram_addrb    = rd_fire ? rd_addr : '0;
    assign rd_data_valid = vpipe[RD_LAT-1];
    assign rd_data       = rd_data_valid ?
        bram_doutb[int'(ipipe[RD_LAT-1])*DATA_W +: DATA_W] : '0;

    always_comb begin
        banks_full = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (st[k] == FULL || st[k] == DRAINING)
                banks_full = banks_full + BW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb         <= '0;
            wcnt       <= '0;
            overflow   <= 1'b0;
            bram_wea   <= '0;
            bram_addra <= '0;
            bram_dina  <= '0;
        end else begin
            bram_wea <= '0;
            if (wr_fire) begin
                bram_wea   <= {{(NUM_BANKS-1){1'b0}}, 1'b1} << wb;
                bram_addra <= wcnt;
                bram_dina  <= wr_data;
                wcnt       <= wr_close ? '0 : wcnt + 1'b1;
                if (wr_close)
                    wb <= nxt(wb);
                if (wr_close && !wr_last)
                    overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb <= '0;
            for (int k = 0; k < NUM_BANKS; k++) begin
                st[k]  <= EMPTY;
                len[k] <= '0;
            end
        end else begin
            if (wr_fire) begin
                st[wb] <= wr_close ? FULL : FILLING;
                if (wr_close)
                    len[wb] <= {1'b0, wcnt} + 1'b1;
            end
            if (rel) begin
                st[rb] <= EMPTY;
                rb     <= nxt(rb);
            end else if (rd_avail && st[rb] == FULL) begin
                st[rb] <= DRAINING;
            end
        end
    end

    // Bank index travels with each read so in-flight reads survive a release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe <= '0;
            for (int i = 0; i < RD_LAT; i++)
                ipipe[i] <= '0;
        end else begin
            vpipe[0] <= rd_fire;
            ipipe[0] <= rb;
            for (int i = 1; i < RD_LAT; i++) begin
                vpipe[i] <= vpipe[i-1];
                ipipe[i] <= ipipe[i-1];
            end
        end
    end

endmodule

// File: tb/tb_pingpong_bank_ctrl.sv
// tb_pingpong_bank_ctrl: directed vectors for the ping-pong bank controller.
// Two 16-deep 32-bit banks with a 2-cycle BRAM read model.
module tb_pingpong_bank_ctrl;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NB = 2;
    localparam int RL = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          wr_last;
    logic          rd_avail;
    logic [AW:0]   rd_len;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_data_valid;
    logic          rd_done;
    logic [1:0]    banks_full;
    logic          overflow;
    logic [NB-1:0] bram_wea;
    logic [AW-1:0] bram_addra;
    logic [DW-1:0] bram_dina;
    logic [AW-1:0] bram_addrb;
    logic [NB*DW-1:0] bram_doutb;

    int nvec = 0;
    int nerr = 0;

    pingpong_bank_ctrl #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_BANKS(NB), .RD_LAT(RL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .wr_last(wr_last),
        .rd_avail(rd_avail), .rd_len(rd_len),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .rd_done(rd_done), .banks_full(banks_full),
        .overflow(overflow), .bram_wea(bram_wea),
        .bram_addra(bram_addra), .bram_dina(bram_dina),
        .bram_addrb(bram_addrb), .bram_doutb(bram_doutb)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [NB][16];
    logic [DW-1:0] s0 [NB];
    logic [DW-1:0] s1 [NB];

    always @(posedge clk) begin
        for (int k = 0; k < NB; k++) begin
            if (bram_wea[k])
                mem[k][bram_addra] <= bram_dina;
            s0[k] <= mem[k][bram_addrb];
            s1[k] <= s0[k];
        end
    end

    assign bram_doutb = {s1[1], s1[0]};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_wea"}, 64'(bram_wea), 0);
        chk({tag, "_addra"}, 64'(bram_addra), 0);
        chk({tag, "_dina"}, 64'(bram_dina), 0);
        chk({tag, "_avail"}, 64'(rd_avail), 0);
        chk({tag, "_len"}, 64'(rd_len), 0);
        chk({tag, "_dvalid"}, 64'(rd_data_valid), 0);
        chk({tag, "_rdata"}, 64'(rd_data), 0);
        chk({tag, "_bfull"}, 64'(banks_full), 0);
        chk({tag, "_ovf"}, 64'(overflow), 0);
        chk({tag, "_wrdy"}, 64'(wr_ready), 1);
    endtask

    initial begin
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        wr_last  = 1'b0;
        rd_en    = 1'b0;
        rd_addr  = '0;
        rd_done  = 1'b0;
        repeat (2) tick;
        chk_rst("rst");
        rst_n = 1'b1;
        tick;

        // four-word frame into bank0
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_data  = 32'h1000_0000 + DW'(i);
            wr_last  = (i == 3);
            tick;
            chk("t1_wea", 64'(bram_wea), 64'h1);
            chk("t1_addra", 64'(bram_addra), 64'(i));
            chk("t1_dina", 64'(bram_dina), 64'(32'h1000_0000 + i));
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        chk("t1_avail_early", 64'(rd_avail), 0);
        tick;
        chk("t1_avail", 64'(rd_avail), 1);
        chk("t1_len", 64'(rd_len), 4);
        chk("t1_bfull", 64'(banks_full), 1);
        chk("t1_ovf", 64'(overflow), 0);
        chk("t1_wrdy", 64'(wr_ready), 1);

        // back-to-back reads addr 3 then 0
        rd_en   = 1'b1;
        rd_addr = 4'd3;
        #1;
        chk("t3_addrb", 64'(bram_addrb), 3);
        tick;
        chk("t3_dv0", 64'(rd_data_valid), 0);
        rd_addr = 4'd0;
        tick;
        chk("t3_dv1", 64'(rd_data_valid), 1);
        chk("t3_d3", 64'(rd_data), 64'h1000_0003);
        rd_en = 1'b0;
        tick;
        chk("t3_dv2", 64'(rd_data_valid), 1);
        chk("t3_d0", 64'(rd_data), 64'h1000_0000);
        tick;
        chk("t3_dv3", 64'(rd_data_valid), 0);

        // fill bank1 with eight words while bank0 is held
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1;
            wr_data  = 32'h2000_0000 + DW'(i);
            wr_last  = (i == 7);
            tick;
            if (i == 0)
                chk("t2_wea1", 64'(bram_wea), 64'h2);
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        chk("t2_bfull", 64'(banks_full), 2);
        chk("t2_wrdy", 64'(wr_ready), 0);
        tick;
        chk("t2_wrdy_hold", 64'(wr_ready), 0);

        // read and release in the same cycle
        rd_en   = 1'b1;
        rd_addr = 4'd1;
        rd_done = 1'b1;
        tick;
        rd_done = 1'b0;
        chk("t5_avail", 64'(rd_avail), 1);
        chk("t5_len", 64'(rd_len), 8);
        chk("t5_wrdy", 64'(wr_ready), 1);
        chk("t5_bfull", 64'(banks_full), 1);
        tick;
        chk("t5_dv_old", 64'(rd_data_valid), 1);
        chk("t5_d_old", 64'(rd_data), 64'h1000_0001);
        rd_en    = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 32'h3000_0000;
        tick;
        chk("t5_dv_new", 64'(rd_data_valid), 1);
        chk("t5_d_new", 64'(rd_data), 64'h2000_0001);
        chk("t2_wea0", 64'(bram_wea), 64'h1);
        chk("t2_addra0", 64'(bram_addra), 0);

        // run bank0 to depth with no last: auto-close
        for (int i = 1; i < 16; i++) begin
            wr_valid = 1'b1;
            wr_data  = 32'h3000_0000 + DW'(i);
            wr_last  = 1'b0;
            tick;
        end
        wr_valid = 1'b0;
        chk("t4_addra15", 64'(bram_addra), 15);
        chk("t4_ovf", 64'(overflow), 1);
        chk("t4_wrdy", 64'(wr_ready), 0);
        chk("t4_bfull", 64'(banks_full), 2);
        rd_done = 1'b1;
        tick;
        rd_done = 1'b0;
        chk("t4_avail", 64'(rd_avail), 1);
        chk("t4_len", 64'(rd_len), 16);
        chk("t4_wrdy1", 64'(wr_ready), 1);
        rd_en    = 1'b1;
        rd_addr  = 4'd15;
        wr_valid = 1'b1;
        wr_data  = 32'h4000_0000;
        wr_last  = 1'b1;
        tick;
        chk("t4_wea1", 64'(bram_wea), 64'h2);
        chk("t4_addra1", 64'(bram_addra), 0);
        chk("t4_ovf_sticky", 64'(overflow), 1);
        rd_en    = 1'b0;
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        tick;
        chk("t4_dv", 64'(rd_data_valid), 1);
        chk("t4_d15", 64'(rd_data), 64'h3000_000f);
        rd_en   = 1'b1;
        rd_addr = 4'd0;
        tick;
        rd_en   = 1'b0;
        rd_done = 1'b1;
        tick;
        chk("t4_d0", 64'(rd_data), 64'h3000_0000);
        rd_done  = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 32'h5000_0000;
        rd_en    = 1'b1;
        rd_addr  = 4'd0;
        chk("t6_avail", 64'(rd_avail), 1);
        tick;
        chk("t6_wea", 64'(bram_wea), 64'h1);

        // reset with a fill and a read in flight
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        rd_en    = 1'b0;
        #1;
        chk_rst("t6_rst");
        tick;
        chk("t6_dv_rst", 64'(rd_data_valid), 0);
        rst_n = 1'b1;
        tick;
        chk("t6_dv_post", 64'(rd_data_valid), 0);
        chk("t6_wrdy_post", 64'(wr_ready), 1);

        // read and release with nothing presented are ignored
        rd_en   = 1'b1;
        rd_addr = 4'd5;
        rd_done = 1'b1;
        #1;
        chk("t7_addrb", 64'(bram_addrb), 0);
        tick;
        rd_en   = 1'b0;
        rd_done = 1'b0;
        chk("t7_bfull", 64'(banks_full), 0);
        chk("t7_avail", 64'(rd_avail), 0);
        tick;
        chk("t7_dv", 64'(rd_data_valid), 0);
        chk("t7_wrdy", 64'(wr_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
